// File: rtl/data_memory.sv
// Byte-addressed, big-endian data memory with a single-request/one-cycle-completion handshake.
// On reset the block can zero-fill the array one 32-bit word per cycle before it accepts
// requests.
//
// Ports
//   clk         rising-edge clock
//   i_reset_n   asynchronous active-low reset
//   i_req       request strobe; accepted when o_ready is also high
//   i_we        1 = store, 0 = load
//   i_size      00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   i_unsigned  load zero-extend (1) or sign-extend (0)
//   i_addr      byte address
//   i_data      store data, right-justified
//   o_ready     block can accept a request
//   o_valid     one-cycle completion pulse per accepted request
//   o_err       coincident with o_valid for a faulted request
//   o_data      registered load result, held until the next successful load
module data_memory #(
  parameter int unsigned NB_ADDR   = 8,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               i_reset_n,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [31:0]        i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic               o_err,
  output logic [31:0]        o_data
);

  localparam int unsigned Depth = 2 ** NB_ADDR;
  localparam int unsigned NbCnt = NB_ADDR - 2;

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  logic [7:0]       mem_q [Depth];
  state_e           state_q;
  logic [NbCnt-1:0] cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic             err_q;
  logic [31:0]      data_q;

  logic             accept;
  logic             fault;
  logic [31:0]      load_val;

  // Aligned byte addresses inside the addressed halfword / word.
  logic [NB_ADDR-1:0] h0, h1, w0, w1, w2, w3;
  logic [NB_ADDR-1:0] f0, f1, f2, f3;
  logic [7:0]         rd_b;
  logic [15:0]        rd_h;
  logic [31:0]        rd_w;

  assign accept = i_req & ready_q;

  always_comb begin
    fault = 1'b1;
    unique case (i_size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = i_addr[0];
      2'b10:   fault = |i_addr[1:0];
      default: fault = 1'b1;
    endcase
  end

  assign h0 = {i_addr[NB_ADDR-1:1], 1'b0};
  assign h1 = {i_addr[NB_ADDR-1:1], 1'b1};
  assign w0 = {i_addr[NB_ADDR-1:2], 2'b00};
  assign w1 = {i_addr[NB_ADDR-1:2], 2'b01};
  assign w2 = {i_addr[NB_ADDR-1:2], 2'b10};
  assign w3 = {i_addr[NB_ADDR-1:2], 2'b11};
  assign f0 = {cnt_q, 2'b00};
  assign f1 = {cnt_q, 2'b01};
  assign f2 = {cnt_q, 2'b10};
  assign f3 = {cnt_q, 2'b11};

  // Big-endian: lowest address is the most significant byte.
  assign rd_b = mem_q[i_addr];
  assign rd_h = {mem_q[h0], mem_q[h1]};
  assign rd_w = {mem_q[w0], mem_q[w1], mem_q[w2], mem_q[w3]};

  always_comb begin
    load_val = rd_w;
    unique case (i_size)
      2'b00:   load_val = i_unsigned ? {24'h0, rd_b} : {{24{rd_b[7]}}, rd_b};
      2'b01:   load_val = i_unsigned ? {16'h0, rd_h} : {{16{rd_h[15]}}, rd_h};
      default: load_val = rd_w;
    endcase
  end

  // Control state, completion pulses and the load result register.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      if (INIT_ZERO) state_q <= StInit;
      else           state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      valid_q <= accept;
      err_q   <= accept & fault;
      if (accept && !i_we && !fault) data_q <= load_val;
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // Array has no reset. While reset is held with INIT_ZERO set, word 0 is rewritten with
  // zeros; that is harmless because the fill always follows release.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem_q[f0] <= 8'h00;
      mem_q[f1] <= 8'h00;
      mem_q[f2] <= 8'h00;
      mem_q[f3] <= 8'h00;
    end else if (accept && i_we && !fault) begin
      case (i_size)
        2'b00: mem_q[i_addr] <= i_data[7:0];
        2'b01: begin
          mem_q[h0] <= i_data[15:8];
          mem_q[h1] <= i_data[7:0];
        end
        default: begin
          mem_q[w0] <= i_data[31:24];
          mem_q[w1] <= i_data[23:16];
          mem_q[w2] <= i_data[15:8];
          mem_q[w3] <= i_data[7:0];
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_err   = err_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic        clk;
  logic        i_reset_n;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [7:0]  i_addr;
  logic [31:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic        o_err;
  logic [31:0] o_data;

  data_memory #(
    .NB_ADDR  (8),
    .INIT_ZERO(1'b1)
  ) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_req     (i_req),
    .i_we      (i_we),
    .i_size    (i_size),
    .i_unsigned(i_unsigned),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_err     (o_err),
    .o_data    (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] exp_data;
    logic        exp_err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [7:0] addr,
                              logic [31:0] data, logic [31:0] exp_data, logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.data = data;
    v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Called at posedge+1: drive one request; record the expectation if it will be accepted.
  task automatic drive(int idx, vec_t v);
    exp_t e;
    i_req = 1'b1; i_we = v.we; i_size = v.size; i_unsigned = v.uns;
    i_addr = v.addr; i_data = v.data;
    if (o_ready) begin
      e.idx = idx; e.exp_data = v.exp_data; e.exp_err = v.exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Count rising edges after release until o_ready goes high (bounded).
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_ready) break;
    end
    i_req = 1'b0;
  endtask

  // Scoreboard: compare every completion away from the active edge.
  always @(negedge clk) begin
    if (o_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("err[%0d]", e.idx), {31'h0, o_err}, {31'h0, e.exp_err});
        chk($sformatf("data[%0d]", e.idx), o_data, e.exp_data);
      end
    end
  end

  initial begin
    int cyc;
    i_reset_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b10; i_unsigned = 1'b0;
    i_addr = 8'h00; i_data = 32'h0;

    vecs.push_back(mk(0, 2'b10, 0, 8'hFC, 32'h0,        32'h0000_0000, 0));
    vecs.push_back(mk(1, 2'b10, 0, 8'h10, 32'hA1B2C3D4, 32'h0000_0000, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h10, 32'h0,        32'hFFFF_FFA1, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h11, 32'h0,        32'hFFFF_FFB2, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h12, 32'h0,        32'hFFFF_FFC3, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h13, 32'h0,        32'hFFFF_FFD4, 0));
    vecs.push_back(mk(0, 2'b00, 1, 8'h11, 32'h0,        32'h0000_00B2, 0));
    vecs.push_back(mk(1, 2'b01, 0, 8'h22, 32'h8001,     32'h0000_00B2, 0));
    vecs.push_back(mk(0, 2'b01, 0, 8'h22, 32'h0,        32'hFFFF_8001, 0));
    vecs.push_back(mk(0, 2'b01, 1, 8'h22, 32'h0,        32'h0000_8001, 0));
    vecs.push_back(mk(0, 2'b10, 0, 8'h20, 32'h0,        32'h0000_8001, 0));
    vecs.push_back(mk(1, 2'b10, 0, 8'h05, 32'hDEADBEEF, 32'h0000_8001, 1));
    vecs.push_back(mk(0, 2'b01, 0, 8'h03, 32'h0,        32'h0000_8001, 1));
    vecs.push_back(mk(0, 2'b11, 0, 8'h04, 32'h0,        32'h0000_8001, 1));
    vecs.push_back(mk(0, 2'b10, 0, 8'h04, 32'h0,        32'h0000_0000, 0));
    vecs.push_back(mk(1, 2'b00, 0, 8'h40, 32'h5A,       32'h0000_0000, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h40, 32'h0,        32'h0000_005A, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'h10, 32'h0,        32'hA1B2_C3D4, 0));
    vecs.push_back(mk(1, 2'b10, 0, 8'h50, 32'h007F7F80, 32'hA1B2_C3D4, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h53, 32'h0,        32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h52, 32'h0,        32'h0000_007F, 0));
    vecs.push_back(mk(0, 2'b01, 0, 8'h52, 32'h0,        32'h0000_7F80, 0));
    vecs.push_back(mk(1, 2'b00, 0, 8'h41, 32'hFFFF_FF11, 32'h0000_7F80, 0));
    vecs.push_back(mk(0, 2'b01, 1, 8'h40, 32'h0,        32'h0000_5A11, 0));

    // Reset values while reset is held.
    #3;
    chk("rst_ready", {31'h0, o_ready}, 32'h0);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_err",   {31'h0, o_err},   32'h0);
    chk("rst_data",  o_data,           32'h0);

    // Release, then reset again 30 cycles into the fill, with i_req held high throughout.
    @(posedge clk); #1;
    i_req = 1'b1;
    i_reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("init_rst_ready", {31'h0, o_ready}, 32'h0);
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    wait_ready(cyc);
    chk("init_cycles", cyc, 32'd64);

    // Vector table, back to back.
    foreach (vecs[i]) drive(i, vecs[i]);
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("table_drained", sb.size(), 32'd0);

    // Reset during a transfer: the pending completion is dropped and outputs clear at once.
    drive(100, mk(0, 2'b10, 0, 8'h10, 32'h0, 32'hA1B2_C3D4, 0));
    i_req = 1'b0;
    i_reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, o_valid}, 32'h0);
    chk("midrst_data",  o_data,           32'h0);
    chk("midrst_ready", {31'h0, o_ready}, 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    wait_ready(cyc);
    chk("reinit_cycles", cyc, 32'd64);

    // The fill that followed reset has cleared previously stored words.
    drive(200, mk(0, 2'b10, 0, 8'h10, 32'h0, 32'h0000_0000, 0));
    drive(201, mk(0, 2'b00, 1, 8'h40, 32'h0, 32'h0000_0000, 0));
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
